// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and types for the fetch/decode sequencer.
package fetch_sequencer_pkg;

    // Common-bus source encoding
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    // Register-reference / IO opcode never takes an indirect fetch
    localparam logic [2:0] OPC_REG_IO = 3'd7;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StInit = 3'd1,
        StT0   = 3'd2,
        StT1   = 3'd3,
        StT2   = 3'd4,
        StT3   = 3'd5,
        StExec = 3'd6
    } state_e;

    // True when T3 must fetch the effective address from memory
    function automatic logic needs_indirect(input logic [2:0] opc, input logic i_bit);
        return (opc != OPC_REG_IO) && i_bit;
    endfunction

endpackage

// File: rtl/fetch_sequencer_seq_counter.sv
// 4-bit sequence counter: synchronous clear (priority) and saturating increment.
module fetch_sequencer_seq_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] count
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: clear wins, increment holds at 15
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 4'd0;
        end else if (inc && (count_q != 4'hF)) begin
            count_d = count_q + 4'd1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-cycle timing and control: fetch, decode, indirect, then execute handoff.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    input  logic [15:0] ir_q,
    input  logic        exec_done,
    output logic [2:0]  bus_sel,
    output logic        mem_read,
    output logic        pc_load,
    output logic        pc_inc,
    output logic        pc_clr,
    output logic        ar_load,
    output logic        ar_inc,
    output logic        ar_clr,
    output logic        ir_load,
    output logic [2:0]  opcode,
    output logic        ind,
    output logic        exec_start,
    output logic [3:0]  sc,
    output logic        busy
);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] opcode_q;
    logic       ind_q;
    logic       halt_pending_q;
    logic       halt_pending_d;
    logic       leave_exec;
    logic       sc_clr;
    logic       sc_inc;

    // Address field is consumed by AR directly over the bus, not here
    logic unused_ir_addr;
    assign unused_ir_addr = ^ir_q[11:0];

    assign leave_exec = (state_q == StExec) && exec_done;

    // Sequence counter: held at 0 outside the instruction cycle, cleared on handoff back
    assign sc_clr = (state_q == StIdle) || (state_q == StInit) || leave_exec;
    assign sc_inc = 1'b1;

    fetch_sequencer_seq_counter u_seq_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sc_clr),
        .inc   (sc_inc),
        .count (sc)
    );

    // Halt request is sticky until the current instruction completes
    always_comb begin
        halt_pending_d = halt_pending_q;
        if (leave_exec) begin
            halt_pending_d = 1'b0;
        end else if (halt) begin
            halt_pending_d = 1'b1;
        end
    end

    // State, decoded IR fields and halt request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            opcode_q       <= 3'd0;
            ind_q          <= 1'b0;
            halt_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            halt_pending_q <= halt_pending_d;
            if (state_q == StT2) begin
                opcode_q <= ir_q[14:12];
                ind_q    <= ir_q[15];
            end
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StInit;
            StInit: state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   state_d = StT2;
            StT2:   state_d = StT3;
            StT3:   state_d = StExec;
            StExec: if (exec_done) state_d = halt_pending_q ? StIdle : StT0;
            default: state_d = StIdle;
        endcase
    end

    // Moore command decode; at most one command per register in any state
    always_comb begin
        bus_sel  = BUS_NONE;
        mem_read = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_clr   = 1'b0;
        ar_load  = 1'b0;
        ar_inc   = 1'b0;
        ar_clr   = 1'b0;
        ir_load  = 1'b0;
        unique case (state_q)
            StInit: begin
                pc_clr = 1'b1;
                ar_clr = 1'b1;
            end
            StT0: begin
                bus_sel = BUS_PC;
                ar_load = 1'b1;
            end
            StT1: begin
                bus_sel  = BUS_MEM;
                mem_read = 1'b1;
                ir_load  = 1'b1;
                pc_inc   = 1'b1;
            end
            StT2: begin
                bus_sel = BUS_IR;
                ar_load = 1'b1;
            end
            StT3: begin
                if (needs_indirect(opcode_q, ind_q)) begin
                    bus_sel  = BUS_MEM;
                    mem_read = 1'b1;
                    ar_load  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // sc saturates above 4, so sc==4 in EXEC marks only its first cycle
    assign exec_start = (state_q == StExec) && (sc == 4'd4);
    assign busy       = (state_q != StIdle);
    assign opcode     = opcode_q;
    assign ind        = ind_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and random-invariant bench for fetch_sequencer.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic [15:0] ir_q;
    logic        exec_done;
    logic [2:0]  bus_sel;
    logic        mem_read;
    logic        pc_load, pc_inc, pc_clr;
    logic        ar_load, ar_inc, ar_clr;
    logic        ir_load;
    logic [2:0]  opcode;
    logic        ind;
    logic        exec_start;
    logic [3:0]  sc;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // {mem_read, pc_load, pc_inc, pc_clr, ar_load, ar_inc, ar_clr, ir_load, exec_start, busy}
    logic [9:0] cmd;
    assign cmd = {mem_read, pc_load, pc_inc, pc_clr, ar_load, ar_inc, ar_clr, ir_load,
                  exec_start, busy};

    localparam logic [9:0] C_IDLE   = 10'b0000000000;
    localparam logic [9:0] C_INIT   = 10'b0001001001;
    localparam logic [9:0] C_T0     = 10'b0000100001;
    localparam logic [9:0] C_T1     = 10'b1010000101;
    localparam logic [9:0] C_T2     = 10'b0000100001;
    localparam logic [9:0] C_T3D    = 10'b0000000001;
    localparam logic [9:0] C_T3I    = 10'b1000100001;
    localparam logic [9:0] C_EXEC1  = 10'b0000000011;
    localparam logic [9:0] C_EXECN  = 10'b0000000001;

    fetch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt       (halt),
        .ir_q       (ir_q),
        .exec_done  (exec_done),
        .bus_sel    (bus_sel),
        .mem_read   (mem_read),
        .pc_load    (pc_load),
        .pc_inc     (pc_inc),
        .pc_clr     (pc_clr),
        .ar_load    (ar_load),
        .ar_inc     (ar_inc),
        .ar_clr     (ar_clr),
        .ir_load    (ir_load),
        .opcode     (opcode),
        .ind        (ind),
        .exec_start (exec_start),
        .sc         (sc),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_phase(input string tag, input logic [2:0] exp_bus,
                               input logic [9:0] exp_cmd, input logic [3:0] exp_sc);
        check({tag, "_bus"}, {13'd0, bus_sel}, {13'd0, exp_bus});
        check({tag, "_cmd"}, {6'd0, cmd}, {6'd0, exp_cmd});
        check({tag, "_sc"}, {12'd0, sc}, {12'd0, exp_sc});
    endtask

    initial begin
        int exp_sc;
        int instr_cnt;
        int cyc;

        rst_n     = 1'b0;
        start     = 1'b0;
        halt      = 1'b0;
        ir_q      = 16'h0000;
        exec_done = 1'b0;
        #1;
        check_phase("reset", 3'd0, C_IDLE, 4'd0);
        check("reset_opcode", {13'd0, opcode}, 16'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_phase("idle", 3'd0, C_IDLE, 4'd0);

        // Instruction 1: direct, opcode 2
        start = 1'b1;
        step();
        check_phase("i1_init", 3'd0, C_INIT, 4'd0);
        start = 1'b0;
        step();
        check_phase("i1_t0", 3'd2, C_T0, 4'd0);
        ir_q = 16'h2005;
        step();
        check_phase("i1_t1", 3'd7, C_T1, 4'd1);
        step();
        check_phase("i1_t2", 3'd5, C_T2, 4'd2);
        step();
        check_phase("i1_t3", 3'd0, C_T3D, 4'd3);
        check("i1_opcode", {13'd0, opcode}, 16'd2);
        check("i1_ind", {15'd0, ind}, 16'd0);
        step();
        check_phase("i1_exec", 3'd0, C_EXEC1, 4'd4);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check_phase("i2_t0", 3'd2, C_T0, 4'd0);

        // Instruction 2: indirect, opcode 2
        ir_q = 16'hA123;
        step();
        check_phase("i2_t1", 3'd7, C_T1, 4'd1);
        step();
        step();
        check_phase("i2_t3", 3'd7, C_T3I, 4'd3);
        check("i2_opcode", {13'd0, opcode}, 16'd2);
        check("i2_ind", {15'd0, ind}, 16'd1);
        step();
        check_phase("i2_exec", 3'd0, C_EXEC1, 4'd4);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check_phase("i3_t0", 3'd2, C_T0, 4'd0);

        // Instruction 3: opcode 7 with I=1, no indirection; long execute
        ir_q = 16'hF800;
        step();
        step();
        step();
        check_phase("i3_t3", 3'd0, C_T3D, 4'd3);
        check("i3_opcode", {13'd0, opcode}, 16'd7);
        check("i3_ind", {15'd0, ind}, 16'd1);
        for (int i = 0; i < 20; i++) begin
            step();
            exp_sc = (4 + i > 15) ? 15 : 4 + i;
            check_phase("i3_exec", 3'd0, (i == 0) ? C_EXEC1 : C_EXECN, exp_sc[3:0]);
        end
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check_phase("i4_t0", 3'd2, C_T0, 4'd0);

        // Instruction 4: halt pulsed in T1 stops after this instruction
        ir_q = 16'h5ABC;
        step();
        check_phase("i4_t1", 3'd7, C_T1, 4'd1);
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
        check_phase("i4_t3", 3'd0, C_T3D, 4'd3);
        check("i4_opcode", {13'd0, opcode}, 16'd5);
        step();
        check_phase("i4_exec", 3'd0, C_EXEC1, 4'd4);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check_phase("i4_halted", 3'd0, C_IDLE, 4'd0);
        step();
        check_phase("i4_stays_idle", 3'd0, C_IDLE, 4'd0);

        // Restart, then asynchronous reset in the middle of T2
        start = 1'b1;
        step();
        check_phase("re_init", 3'd0, C_INIT, 4'd0);
        start = 1'b0;
        step();
        step();
        ir_q = 16'hB456;
        step();
        check_phase("re_t2", 3'd5, C_T2, 4'd2);
        check("re_opcode_held", {13'd0, opcode}, 16'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_phase("async_rst", 3'd0, C_IDLE, 4'd0);
        check("async_rst_opcode", {13'd0, opcode}, 16'd0);
        step();
        rst_n = 1'b1;

        // Halt in IDLE is retained; exec_done outside EXEC and start mid-run are ignored
        halt = 1'b1;
        step();
        halt = 1'b0;
        check_phase("hidle_idle", 3'd0, C_IDLE, 4'd0);
        start = 1'b1;
        step();
        check_phase("hidle_init", 3'd0, C_INIT, 4'd0);
        step();
        step();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check_phase("hidle_t2", 3'd5, C_T2, 4'd2);
        step();
        step();
        check_phase("hidle_exec", 3'd0, C_EXEC1, 4'd4);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check_phase("hidle_stop", 3'd0, C_IDLE, 4'd0);

        // Random run: per-register single-command invariant every cycle
        instr_cnt = 0;
        cyc       = 0;
        start     = 1'b1;
        while (instr_cnt < 200 && cyc < 20000) begin
            ir_q      = 16'($urandom);
            exec_done = ($urandom_range(0, 3) == 0);
            halt      = ($urandom_range(0, 15) == 0);
            step();
            cyc++;
            check("rnd_pc_one", {15'd0, $countones({pc_load, pc_inc, pc_clr}) <= 1}, 16'd1);
            check("rnd_ar_one", {15'd0, $countones({ar_load, ar_inc, ar_clr}) <= 1}, 16'd1);
            check("rnd_memrd", {15'd0, mem_read}, {15'd0, bus_sel == 3'd7});
            if (!busy) begin
                check("rnd_idle_quiet", {6'd0, cmd}, 16'd0);
            end
            if (exec_start) begin
                check("rnd_start_sc", {12'd0, sc}, 16'd4);
                instr_cnt++;
            end
        end
        check("rnd_instr_count", {15'd0, instr_cnt >= 200}, 16'd1);
        start     = 1'b0;
        halt      = 1'b0;
        exec_done = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
